bcd_stream_divisibility: RTL and testbench



---
 rtl/bcd_stream_divisibility.sv | 131 +++++++++++++
 tb/tb_bcd_stream_divisibility.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_stream_divisibility.sv
`default_nettype none
//==============================================================================
// bcd_stream_divisibility - MSD-first BCD digit stream, running remainder
// modulo DIVISOR, result returned over a valid/ready handshake.
// Rev 1.0
//==============================================================================
module bcd_stream_divisibility #(
    parameter int DIVISOR    = 11,
    parameter int REM_W      = 7,
    parameter int MAX_DIGITS = 8,
    localparam int CNT_W     = $clog2(MAX_DIGITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             digit_valid,
    output logic             digit_ready,
    input  logic [3:0]       digit,
    input  logic             digit_last,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             divisible,
    output logic [REM_W-1:0] remainder,
    output logic             bcd_error,
    output logic             overflow,
    output logic [CNT_W-1:0] digit_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             ovf_q, ovf_d;
    logic             div_q, div_d;

    logic             w_accept;
    logic             w_bad;
    logic [3:0]       w_dval;
    logic [9:0]       w_base;
    logic [9:0]       w_sum;
    logic [REM_W-1:0] w_rem;
    logic             w_cnt_full;

    generate
        if (DIVISOR < 2 || DIVISOR > 99 || (1 << REM_W) < DIVISOR || MAX_DIGITS < 1) begin : g_bad_params
            $error("bcd_stream_divisibility: illegal DIVISOR/REM_W/MAX_DIGITS");
        end
    endgenerate

    assign digit_ready = (state_q != S_DONE);
    assign w_accept    = digit_valid && digit_ready;
    assign w_bad       = (digit > 4'd9);
    assign w_dval      = w_bad ? 4'd0 : digit;

    // A fresh frame starts from a zero base, so IDLE and ACCUM share one reducer.
    assign w_base      = (state_q == S_IDLE) ? 10'd0 : 10'(rem_q);
    assign w_sum       = w_base * 10'd10 + 10'(w_dval);
    assign w_rem       = REM_W'(w_sum % 10'(DIVISOR));
    assign w_cnt_full  = (cnt_q == CNT_W'(MAX_DIGITS));

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        div_d   = div_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    rem_d   = w_rem;
                    cnt_d   = CNT_W'(1);
                    err_d   = w_bad;
                    ovf_d   = 1'b0;
                    div_d   = (w_rem == '0) && !w_bad;
                    state_d = digit_last ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_accept) begin
                    rem_d   = w_rem;
                    cnt_d   = w_cnt_full ? cnt_q : cnt_q + CNT_W'(1);
                    err_d   = err_q | w_bad;
                    ovf_d   = ovf_q | w_cnt_full;
                    div_d   = (w_rem == '0) && !(err_q | w_bad);
                    state_d = digit_last ? S_DONE : S_ACCUM;
                end
            end
            S_DONE: begin
                if (result_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            div_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            div_q   <= div_d;
        end
    end

    assign result_valid = (state_q == S_DONE);
    assign divisible    = div_q;
    assign remainder    = rem_q;
    assign bcd_error    = err_q;
    assign overflow     = ovf_q;
    assign digit_count  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_stream_divisibility.sv
`default_nettype none
//==============================================================================
// tb_bcd_stream_divisibility - directed frames into DIVISOR=11 and DIVISOR=7
// instances sharing one input stream, checked against a value-level model.
// Rev 1.0
//==============================================================================
module tb_bcd_stream_divisibility;

    localparam int MAXD = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       digit_valid = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       digit_last = 1'b0;
    logic       result_ready = 1'b1;

    logic       digit_ready, result_valid, divisible, bcd_error, overflow;
    logic [6:0] remainder;
    logic [3:0] digit_count;

    logic       r7_ready, r7_valid, r7_div, r7_err, r7_ovf;
    logic [6:0] r7_rem;
    logic [3:0] r7_cnt;

    int checks = 0;
    int errors = 0;

    bcd_stream_divisibility #(.DIVISOR(11), .REM_W(7), .MAX_DIGITS(MAXD)) dut (
        .clk(clk), .rst(rst),
        .digit_valid(digit_valid), .digit_ready(digit_ready),
        .digit(digit), .digit_last(digit_last),
        .result_valid(result_valid), .result_ready(result_ready),
        .divisible(divisible), .remainder(remainder),
        .bcd_error(bcd_error), .overflow(overflow), .digit_count(digit_count)
    );

    bcd_stream_divisibility #(.DIVISOR(7), .REM_W(7), .MAX_DIGITS(MAXD)) dut7 (
        .clk(clk), .rst(rst),
        .digit_valid(digit_valid), .digit_ready(r7_ready),
        .digit(digit), .digit_last(digit_last),
        .result_valid(r7_valid), .result_ready(result_ready),
        .divisible(r7_div), .remainder(r7_rem),
        .bcd_error(r7_err), .overflow(r7_ovf), .digit_count(r7_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the frame's decimal value (invalid digits as 0) and its digit count.
    longint m_value = 0;
    int     m_n     = 0;
    bit     m_err   = 0;
    bit     m_open  = 0;
    bit     m_done  = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_value = 0; m_n = 0; m_err = 0; m_open = 0; m_done = 0;
        end else if (!m_done && digit_valid) begin
            if (!m_open) begin
                m_value = 0; m_n = 0; m_err = 0;
            end
            m_value = m_value * 10 + ((digit > 4'd9) ? 0 : longint'(digit));
            m_n++;
            m_err   = m_err | (digit > 4'd9);
            m_open  = !digit_last;
            m_done  = digit_last;
        end else if (m_done && result_ready) begin
            m_done = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("ready11", digit_ready, !m_done);
            chk("valid11", result_valid, m_done);
            chk("rem11", remainder, m_value % 11);
            chk("cnt11", digit_count, (m_n > MAXD) ? MAXD : m_n);
            chk("err11", bcd_error, m_err);
            chk("ovf11", overflow, m_n > MAXD);
            chk("ready7", r7_ready, !m_done);
            chk("valid7", r7_valid, m_done);
            chk("rem7", r7_rem, m_value % 7);
            chk("cnt7", r7_cnt, (m_n > MAXD) ? MAXD : m_n);
            chk("err7", r7_err, m_err);
            chk("ovf7", r7_ovf, m_n > MAXD);
            if (m_done) begin
                chk("div11", divisible, (m_value % 11 == 0) && !m_err);
                chk("div7", r7_div, (m_value % 7 == 0) && !m_err);
            end
        end
    end

    task automatic send(input logic [3:0] d, input logic l);
        int guard = 0;
        digit_valid = 1'b1;
        digit       = d;
        digit_last  = l;
        @(negedge clk);
        while (!digit_ready && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        if (!digit_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual ready=0 required ready=1 at %0t", $time);
        end
        @(posedge clk);
        #1;
        digit_valid = 1'b0;
        digit_last  = 1'b0;
    endtask

    logic [3:0] fq[$];

    task automatic send_frame();
        for (int i = 0; i < fq.size(); i++) begin
            send(fq[i], i == fq.size() - 1);
        end
    endtask

    task automatic chk_result(input string tag, input int rem, input bit dv,
                              input int cnt, input bit er, input bit ov);
        chk({tag, "_valid"}, result_valid, 1);
        chk({tag, "_div"}, divisible, dv);
        chk({tag, "_rem"}, remainder, rem);
        chk({tag, "_cnt"}, digit_count, cnt);
        chk({tag, "_err"}, bcd_error, er);
        chk({tag, "_ovf"}, overflow, ov);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_rem", remainder, 0);
        chk("rst_cnt", digit_count, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_div", divisible, 0);
        chk("rst_ready", digit_ready, 1);

        // digit_last without digit_valid must be ignored
        digit_last = 1'b1;
        repeat (2) @(posedge clk);
        #1 digit_last = 1'b0;

        fq = '{4'd7, 4'd7, 4'd7, 4'd7};
        send_frame();
        chk_result("t1", 0, 1, 4, 0, 0);

        fq = '{4'd2, 4'd1, 4'd2, 4'd1};
        send_frame();
        chk_result("t2a", 9, 0, 4, 0, 0);
        fq = '{4'd9, 4'd2, 4'd4, 4'd0};
        send_frame();
        chk_result("t2b", 0, 1, 4, 0, 0);
        @(posedge clk); #1;

        result_ready = 1'b0;
        fq = '{4'd8, 4'd2, 4'd7, 4'd2};
        send_frame();
        digit_valid = 1'b1; digit = 4'd5; digit_last = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("t3_valid", result_valid, 1);
            chk("t3_div", divisible, 1);
            chk("t3_rem", remainder, 0);
            chk("t3_ready", digit_ready, 0);
        end
        @(posedge clk); #1 result_ready = 1'b1;
        @(posedge clk); #1 result_ready = 1'b0;
        chk("t3_idle_ready", digit_ready, 1);
        chk("t3_idle_valid", result_valid, 0);
        @(posedge clk); #1;
        digit_valid = 1'b0; digit_last = 1'b0;
        chk("t3_next_valid", result_valid, 1);
        chk("t3_next_rem", remainder, 5);
        result_ready = 1'b1;
        @(posedge clk); #1;

        fq = '{4'd1, 4'hA, 4'd1};
        send_frame();
        chk_result("t4", 2, 0, 3, 1, 0);

        fq = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
        send_frame();
        chk_result("t5", 1, 0, 8, 0, 1);

        fq = '{4'd1, 4'd4};
        send_frame();
        chk("t5_d7_valid", r7_valid, 1);
        chk("t5_d7_div", r7_div, 1);
        chk("t5_d7_rem", r7_rem, 0);
        chk_result("t5b", 3, 0, 2, 0, 0);
        @(posedge clk); #1;

        send(4'd3, 1'b0);
        send(4'd4, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("t6_rem", remainder, 0);
        chk("t6_cnt", digit_count, 0);
        chk("t6_valid", result_valid, 0);
        chk("t6_div", divisible, 0);
        chk("t6_err", bcd_error, 0);
        chk("t6_ovf", overflow, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_ready", digit_ready, 1);
        @(posedge clk); #1;
        fq = '{4'd0, 4'd0};
        send_frame();
        chk_result("t6b", 0, 1, 2, 0, 0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
